// File: rtl/rns_set3_pkg.sv
// Shared definitions for the {2^(n+1)-1, 2^n, 2^n-1} RNS multiply-accumulate.
// Holds the default base exponent, the three moduli derived from it and the
// two-state FSM encoding used by rns_mac_set3.
package rns_set3_pkg;

   // Default RNS base exponent and the moduli it selects.
   localparam int unsigned N  = 4;
   localparam int unsigned M1 = (2 ** (N + 1)) - 1;
   localparam int unsigned M2 = 2 ** N;
   localparam int unsigned M3 = (2 ** N) - 1;

   // ACC: accepting operand beats. HOLD: presenting a finished dot product.
   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

endpackage : rns_set3_pkg

// File: rtl/mod_mac_2k1.sv
// Combinational modulo-(2^k-1) multiply-accumulate: o_sum_c = (i_acc + i_a*i_w) mod (2^k-1).
// An all-ones input residue is the redundant encoding of zero and is treated as 0.
// The result is always canonical (0..2^k-2), never all-ones.
// Ports:
//   i_acc   [k-1:0]  running residue
//   i_a     [k-1:0]  operand residue
//   i_w     [k-1:0]  operand residue
//   o_sum_c [k-1:0]  updated residue (combinational)
module mod_mac_2k1 #(
   parameter int unsigned k = 5
) (
   input  logic [k-1:0] i_acc,
   input  logic [k-1:0] i_a,
   input  logic [k-1:0] i_w,
   output logic [k-1:0] o_sum_c
);

   localparam int unsigned PW   = 2 * k;
   localparam logic [k-1:0] ONES = '1;

   logic [k-1:0]  w_a;
   logic [k-1:0]  w_w;
   logic [k-1:0]  w_acc;
   logic [PW-1:0] w_prod;
   logic [k:0]    w_pfold;
   logic [k-1:0]  w_pwrap;
   logic [k-1:0]  w_pmod;
   logic [k:0]    w_sfold;
   logic [k-1:0]  w_swrap;

   // Fold the redundant zero encoding to the canonical one.
   assign w_a   = (i_a   == ONES) ? '0 : i_a;
   assign w_w   = (i_w   == ONES) ? '0 : i_w;
   assign w_acc = (i_acc == ONES) ? '0 : i_acc;

   assign w_prod = PW'(w_a) * PW'(w_w);

   // 2^k == 1 mod (2^k-1): add the product halves, then add the carry back in.
   // With canonical operands the second addition cannot overflow k bits.
   assign w_pfold = {1'b0, w_prod[k-1:0]} + {1'b0, w_prod[PW-1:k]};
   assign w_pwrap = w_pfold[k-1:0] + k'(w_pfold[k]);
   assign w_pmod  = (w_pwrap == ONES) ? '0 : w_pwrap;

   // End-around-carry add of the accumulator, then canonicalise.
   assign w_sfold = {1'b0, w_pmod} + {1'b0, w_acc};
   assign w_swrap = w_sfold[k-1:0] + k'(w_sfold[k]);
   assign o_sum_c = (w_swrap == ONES) ? '0 : w_swrap;

endmodule : mod_mac_2k1

// File: rtl/rns_mac_set3.sv
// Three-channel RNS dot-product engine over moduli {2^(n+1)-1, 2^n, 2^n-1}.
// Accumulates LEN accepted beats of a_i*w_i per channel, then holds the result
// until the consumer takes it.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   a1/a2/a3, w1/w2/w3  operand residues (widths n+1 / n / n)
//   in_valid/in_ready   operand beat handshake
//   acc1/acc2/acc3      accumulated residues (partial sums while out_valid=0)
//   out_valid/out_ready result handshake
module rns_mac_set3
   import rns_set3_pkg::*;
#(
   parameter int unsigned n   = N,
   parameter int unsigned LEN = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [n:0]   a1,
   input  logic [n-1:0] a2,
   input  logic [n-1:0] a3,
   input  logic [n:0]   w1,
   input  logic [n-1:0] w2,
   input  logic [n-1:0] w3,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [n:0]   acc1,
   output logic [n-1:0] acc2,
   output logic [n-1:0] acc3,
   output logic         out_valid,
   input  logic         out_ready
);

   localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

   state_e           r_state;
   state_e           w_state_nx;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nx;
   logic [n:0]       r_acc1;
   logic [n:0]       w_acc1_nx;
   logic [n-1:0]     r_acc2;
   logic [n-1:0]     w_acc2_nx;
   logic [n-1:0]     r_acc3;
   logic [n-1:0]     w_acc3_nx;

   logic [n:0]       w_mac1;
   logic [n-1:0]     w_mac2;
   logic [n-1:0]     w_mac3;

   // Channel 1: modulo 2^(n+1)-1.
   mod_mac_2k1 #(.k(n + 1)) u_ch1 (
      .i_acc   (r_acc1),
      .i_a     (a1),
      .i_w     (w1),
      .o_sum_c (w_mac1)
   );

   // Channel 2: modulo 2^n is plain n-bit truncation.
   assign w_mac2 = r_acc2 + a2 * w2;

   // Channel 3: modulo 2^n-1.
   mod_mac_2k1 #(.k(n)) u_ch3 (
      .i_acc   (r_acc3),
      .i_a     (a3),
      .i_w     (w3),
      .o_sum_c (w_mac3)
   );

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_ACC;
         r_cnt   <= '0;
         r_acc1  <= '0;
         r_acc2  <= '0;
         r_acc3  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_acc1  <= w_acc1_nx;
         r_acc2  <= w_acc2_nx;
         r_acc3  <= w_acc3_nx;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_acc1_nx  = r_acc1;
      w_acc2_nx  = r_acc2;
      w_acc3_nx  = r_acc3;
      case (r_state)
         ST_ACC: begin
            if (in_valid) begin
               w_acc1_nx = w_mac1;
               w_acc2_nx = w_mac2;
               w_acc3_nx = w_mac3;
               // Counter parks at LAST in HOLD; it is cleared on the way out.
               if (r_cnt == LAST) begin
                  w_state_nx = ST_HOLD;
               end else begin
                  w_cnt_nx = r_cnt + CNT_W'(1);
               end
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               w_state_nx = ST_ACC;
               w_cnt_nx   = '0;
               w_acc1_nx  = '0;
               w_acc2_nx  = '0;
               w_acc3_nx  = '0;
            end
         end
         default: begin
            w_state_nx = ST_ACC;
         end
      endcase
   end

   assign in_ready  = (r_state == ST_ACC);
   assign out_valid = (r_state == ST_HOLD);
   assign acc1      = r_acc1;
   assign acc2      = r_acc2;
   assign acc3      = r_acc3;

endmodule : rns_mac_set3

// File: doc/rns_mac_set3.md
RNS_MAC_SET3 -- requirements
Module: rns_mac_set3

Interface
REQ-001 SHALL have parameter n, default 4, the RNS base exponent.
REQ-002 SHALL have parameter LEN, default 8, the accumulation length in beats (LEN >= 1).
REQ-003 SHALL use the fixed moduli set m1 = 2^(n+1)-1 (channel 1), m2 = 2^n (channel 2), m3 = 2^n-1 (channel 3).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have ports a1 / a2 / a3, inputs, widths n+1 / n / n: activation residues.
REQ-007 SHALL have ports w1 / w2 / w3, inputs, widths n+1 / n / n: weight residues.
REQ-008 SHALL have port in_valid, input, 1 bit: operand beat present.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts a beat.
REQ-010 SHALL have ports acc1 / acc2 / acc3, outputs, widths n+1 / n / n: accumulated residues.
REQ-011 SHALL have port out_valid, output, 1 bit: acc1..acc3 hold a completed dot product.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer takes the result.

Function
REQ-013 SHALL implement a two-state FSM, ACC and HOLD; in_ready = (state==ACC) and out_valid = (state==HOLD), both registered-state decodes.
REQ-014 SHALL accept a beat only on a clk edge where in_valid && in_ready; on acceptance, acc_i <= (acc_i + a_i*w_i) mod m_i for each channel, and the beat counter increments.
REQ-015 SHALL, on accepting beat number LEN (counter == LEN-1), update the accumulators and move to HOLD; out_valid SHALL rise the next cycle (latency 1 cycle after the last beat).
REQ-016 SHALL, in HOLD with out_ready=1, clear acc1..acc3 and the counter to 0 and return to ACC; in_ready SHALL return high the cycle after.
REQ-017 SHALL, in HOLD with out_ready=0, keep acc1..acc3 stable and in_ready=0; in_valid SHALL be ignored.
REQ-018 SHALL, in ACC with in_valid=0, keep all state unchanged.
REQ-019 SHALL compute channel 2 by truncation to n bits.
REQ-020 SHALL compute channels 1 and 3 with end-around-carry modulo-(2^k-1) multiply and add.
REQ-021 SHALL treat an all-ones input residue on channels 1 and 3 as 0.
REQ-022 SHALL never drive all-ones on acc1 or acc3: the canonical range is 0..m_i-1.
REQ-023 SHALL, when LEN=1, enter HOLD after every accepted beat.
REQ-024 SHALL hold the accumulators in ACC between accepted beats, so acc1..acc3 show partial sums whenever out_valid=0; consumers SHALL sample them only while out_valid=1.

Reset
REQ-025 SHALL, on rst=1 at a clk edge, set state=ACC, counter=0 and acc1=acc2=acc3=0, giving in_ready=1 and out_valid=0 after that edge.
REQ-026 SHALL, on reset mid-accumulation or in HOLD, discard partial or pending results; no beat is accepted on the reset edge.

Structure
REQ-027 SHALL place n, the moduli m1/m2/m3 and the FSM state encoding in shared package rns_set3_pkg.
REQ-028 SHALL use one sub-module, mod_mac_2k1, a modulo-(2^k-1) multiply-accumulate parameterised by k, instantiated with k=n+1 (channel 1) and k=n (channel 3).
REQ-029 SHALL keep the channel-2 path inline.

Verification (n=4, LEN=4: m = 31/16/15)
REQ-030 SHALL cover: four beats a=(3,5,7), w=(2,3,4) -> out_valid one cycle after beat 4 with acc=(24,12,7).
REQ-031 SHALL cover: beat a=(30,15,14), w=(30,15,14), then three zero beats -> acc=(1,1,1).
REQ-032 SHALL cover: a1=31, w1=5, a3=15, w3=9 for all four beats -> acc1=0, acc3=0, with no all-ones ever on acc1/acc3.
REQ-033 SHALL cover: out_ready=0 for 3 cycles in HOLD while in_valid=1 -> acc stable, in_ready=0, no beat consumed; then out_ready=1 -> acc=(0,0,0) and in_ready=1 next cycle.
REQ-034 SHALL cover: rst asserted after 2 of 4 beats, then four beats of scenario REQ-030 -> result (24,12,7) with the pre-reset beats excluded.
REQ-035 SHALL cover: in_valid toggling every other cycle with out_ready held at 1 over two back-to-back dot products -> two correct results and exactly LEN accepts per result.
